// File: rtl/key_segment_stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_segment_stepper_pkg
//  Description : Shared constants for the push-button segment stepper:
//                position range, active-low HEX0 segment patterns and the
//                repeat FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_segment_stepper_pkg;

    localparam int NUM_POS = 7;
    localparam int POS_MAX = 6;

    // One active-low pattern per position, lit segment = bit index
    localparam logic [6:0] SEG_POS0 = 7'b111_1110;
    localparam logic [6:0] SEG_POS1 = 7'b111_1101;
    localparam logic [6:0] SEG_POS2 = 7'b111_1011;
    localparam logic [6:0] SEG_POS3 = 7'b111_0111;
    localparam logic [6:0] SEG_POS4 = 7'b110_1111;
    localparam logic [6:0] SEG_POS5 = 7'b101_1111;
    localparam logic [6:0] SEG_POS6 = 7'b011_1111;

    // Repeat FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Maps a position to its segment pattern; out-of-range codes blank the digit
    function automatic logic [6:0] seg_pattern(input logic [2:0] pos);
        logic [6:0] pat;
        case (pos)
            3'd0:    pat = SEG_POS0;
            3'd1:    pat = SEG_POS1;
            3'd2:    pat = SEG_POS2;
            3'd3:    pat = SEG_POS3;
            3'd4:    pat = SEG_POS4;
            3'd5:    pat = SEG_POS5;
            3'd6:    pat = SEG_POS6;
            default: pat = 7'b111_1111;
        endcase
        return pat;
    endfunction

endpackage : key_segment_stepper_pkg
`default_nettype wire

// File: rtl/key_debounce_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_repeat
//  Description : One active-low push-button: two-flop synchroniser, debounce
//                counter with stable level, and a repeat FSM that emits a
//                one-cycle step request on press, after the initial delay and
//                then at the repeat rate while the key stays held.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_repeat
    import key_segment_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic step_o
);

    localparam logic [CNT_W-1:0] c_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;   // debounced level, active-low
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             step_q, step_d;
    logic             w_pressed;

    assign w_pressed = ~stable_q;
    assign step_o    = step_q;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count while the synchronised level differs, accept it on the last count
    always_comb begin
        deb_cnt_d = '0;
        stable_d  = stable_q;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == c_DEB_LAST) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q  <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Repeat FSM state, timer and registered step request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            step_q  <= step_d;
        end
    end

    // Next state; release wins over a same-cycle timer expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Release always returns here, so a pressed level in IDLE
                // can only be the first cycle after a fresh press.
                if (w_pressed) state_d = ST_DELAY;
            end
            ST_DELAY: begin
                if (!w_pressed)                state_d = ST_IDLE;
                else if (tmr_q == c_DELAY_LAST) state_d = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (!w_pressed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer and step request for the coming cycle
    always_comb begin
        tmr_d  = tmr_q;
        step_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_d  = '0;
                step_d = w_pressed;
            end
            ST_DELAY: begin
                if (!w_pressed) begin
                    tmr_d = '0;
                end else if (tmr_q == c_DELAY_LAST) begin
                    tmr_d  = '0;
                    step_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!w_pressed) begin
                    tmr_d = '0;
                end else if (tmr_q == c_RATE_LAST) begin
                    tmr_d  = '0;
                    step_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: tmr_d = '0;
        endcase
    end

endmodule : key_debounce_repeat
`default_nettype wire

// File: rtl/key_segment_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : key_segment_stepper
//  Description : Steps a single lit HEX0 segment around positions a..g.
//                KEY0 steps forward, KEY1 backward, with debounce and
//                auto-repeat; simultaneous requests cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_segment_stepper
    import key_segment_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic [1:0] iKEY,
    output logic [6:0] oHEX0_D,
    output logic [2:0] oPOS,
    output logic       oSTEP
);

    localparam logic [2:0] c_POS_MAX = 3'(POS_MAX);

    logic [1:0] w_step;             // bit0 forward request, bit1 backward request
    logic [2:0] pos_q, pos_d;
    logic [6:0] hex_q, hex_d;
    logic       step_q, step_d;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            key_debounce_repeat #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .CNT_W           (CNT_W)
            ) u_key (
                .clk_i   (iCLK_50),
                .rst_i   (iRST),
                .key_n_i (iKEY[k]),
                .step_o  (w_step[k])
            );
        end
    endgenerate

    // Wrap-around position update; opposing requests cancel
    always_comb begin
        pos_d  = pos_q;
        step_d = 1'b0;
        case (w_step)
            2'b01: begin
                pos_d  = (pos_q == c_POS_MAX) ? 3'd0 : pos_q + 3'd1;
                step_d = 1'b1;
            end
            2'b10: begin
                pos_d  = (pos_q == 3'd0) ? c_POS_MAX : pos_q - 3'd1;
                step_d = 1'b1;
            end
            default: begin
                pos_d  = pos_q;
                step_d = 1'b0;
            end
        endcase
        hex_d = seg_pattern(pos_d);
    end

    // Position, segment and step-pulse registers update together
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            pos_q  <= 3'd0;
            hex_q  <= SEG_POS0;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            hex_q  <= hex_d;
            step_q <= step_d;
        end
    end

    assign oPOS    = pos_q;
    assign oHEX0_D = hex_q;
    assign oSTEP   = step_q;

endmodule : key_segment_stepper
`default_nettype wire

// File: tb/tb_key_segment_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_segment_stepper
//  Description : Self-checking bench for key_segment_stepper. Expected steps
//                (edge index and new position) are queued as keys are driven
//                and matched against every oSTEP pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_segment_stepper;

    localparam int NPOS = 7;
    localparam logic [6:0] SEG_TBL [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h77,
                                           7'h6F, 7'h5F, 7'h3F};

    typedef struct {
        int cyc;
        int pos;
    } exp_t;

    logic       clk;
    logic       iRST;
    logic [1:0] iKEY;
    logic [6:0] oHEX0_D;
    logic [2:0] oPOS;
    logic       oSTEP;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   prev_pos  = 0;
    int   model_pos = 0;
    exp_t sb[$];

    key_segment_stepper #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .CNT_W           (6)
    ) dut (
        .iCLK_50 (clk),
        .iRST    (iRST),
        .iKEY    (iKEY),
        .oHEX0_D (oHEX0_D),
        .oPOS    (oPOS),
        .oSTEP   (oSTEP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    // Edge monitor: count edges, match step pulses against the scoreboard
    always @(posedge clk) begin
        logic rst_s;
        exp_t e;
        cyc++;
        rst_s = iRST;
        #1;
        if (rst_s) begin
            prev_pos = int'(oPOS);
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_step", cyc, e.cyc);
            end
            if (oSTEP === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", int'(oPOS), -1);
                end else begin
                    e = sb.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_pos", int'(oPOS), e.pos);
                    chk("step_hex", int'(oHEX0_D), int'(SEG_TBL[e.pos]));
                end
            end else if (int'(oPOS) != prev_pos) begin
                chk("silent_pos_change", int'(oPOS), prev_pos);
            end
            prev_pos = int'(oPOS);
        end
    end

    // Queue the steps a held key produces: press +7, +27, then every 8 edges
    task automatic push_steps(input int k, input int e0, input int max_off);
        exp_t ent;
        int   o;
        o = 7;
        while (o <= max_off) begin
            model_pos = (k == 0) ? (model_pos + 1) % NPOS : (model_pos + NPOS - 1) % NPOS;
            ent.cyc = e0 + o;
            ent.pos = model_pos;
            sb.push_back(ent);
            o = (o == 7) ? 27 : o + 8;
        end
    endtask

    // Hold one key for ncyc edges, release, settle. The release is seen by
    // the FSM 6 edges later, so steps up to offset ncyc+6 still occur.
    task automatic hold_key(input int k, input int ncyc);
        int e0;
        e0 = cyc + 1;
        iKEY[k] = 1'b0;
        push_steps(k, e0, ncyc + 6);
        repeat (ncyc) @(negedge clk);
        iKEY = 2'b11;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int exp_pos);
        chk({tag, "_pos"}, int'(oPOS), exp_pos);
        chk({tag, "_hex"}, int'(oHEX0_D), int'(SEG_TBL[exp_pos]));
    endtask

    initial begin
        int e0;
        iRST = 1'b1;
        iKEY = 2'b11;
        @(negedge clk);

        // 1: reset state, then idle
        repeat (2) @(negedge clk);
        iRST = 1'b0;
        check_state("reset", 0);
        chk("reset_step", int'(oSTEP), 0);
        repeat (50) @(negedge clk);
        check_state("idle", 0);

        // 2: single forward press, released before the repeat delay
        hold_key(0, 10);
        check_state("single_fwd", 1);

        // 3: glitches one cycle short of the debounce length
        repeat (5) begin
            iKEY[0] = 1'b0;
            repeat (3) @(negedge clk);
            iKEY[0] = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_state("bounce", 1);

        // 4: walk to 6, wrap forward to 0, wrap backward to 6
        repeat (5) hold_key(0, 10);
        check_state("at_six", 6);
        hold_key(0, 10);
        check_state("wrap_fwd", 0);
        hold_key(1, 10);
        check_state("wrap_bwd", 6);

        // 5: long hold, release lands exactly on a repeat expiry
        hold_key(0, 60);
        check_state("held_fwd", model_pos);

        // 6a: both keys in the same cycle cancel
        iKEY = 2'b00;
        repeat (10) @(negedge clk);
        iKEY = 2'b11;
        repeat (20) @(negedge clk);
        check_state("both_keys", model_pos);

        // 6b: reset while forward key is in auto-repeat
        e0 = cyc + 1;
        iKEY[0] = 1'b0;
        push_steps(0, e0, 35);
        repeat (36) @(negedge clk);
        check_state("pre_reset", model_pos);
        iRST = 1'b1;
        @(negedge clk);
        iRST = 1'b0;
        model_pos = 0;
        check_state("mid_repeat_reset", 0);
        chk("mid_repeat_reset_step", int'(oSTEP), 0);
        @(negedge clk);
        iKEY = 2'b11;
        repeat (25) @(negedge clk);
        check_state("after_reset_quiet", 0);
        hold_key(0, 10);
        check_state("repress", 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_segment_stepper
`default_nettype wire
